fan_pwm_ctrl: RTL and testbench

Temperature-driven fan controller that produces the board's `fan_pwm` output. Consumes 12-bit temperature samples from the slow-ADC I2C reader. Runs a four-level hysteretic fan state machine with kick-start and a sample-staleness watchdog, and flags over-temperature for the TX-inhibit path in the core.

---
 rtl/fan_pwm_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_fan_pwm_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fan_pwm_ctrl.sv
// Hysteretic four-level fan controller with kick-start,
// sample watchdog, over-temp flag and glitch-free PWM drive.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   temp       12-bit temperature code (higher = hotter)
//   temp_valid one-cycle strobe qualifying temp
//   fan_pwm    registered PWM output
//   fan_state  current level 0=OFF 1=LOW 2=HIGH 3=FULL
//   over_temp  over-temperature flag with hysteresis
//   temp_stale watchdog tripped (no sample for STALE_CYCLES)
module fan_pwm_ctrl #(
  parameter int PRESCALE     = 300,
  parameter int T_ON         = 1200,
  parameter int T_HIGH       = 1400,
  parameter int T_FULL       = 1600,
  parameter int T_OVER       = 1800,
  parameter int HYST         = 40,
  parameter int KICK_PERIODS = 8,
  parameter int STALE_CYCLES = 76800000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] temp,
  input  logic        temp_valid,
  output logic        fan_pwm,
  output logic [1:0]  fan_state,
  output logic        over_temp,
  output logic        temp_stale
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_FULL = 2'd3
  } state_e;

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int KW =
    (KICK_PERIODS > 0) ? $clog2(KICK_PERIODS + 1) : 1;
  localparam int WW = $clog2(STALE_CYCLES + 1);

  localparam logic [PW-1:0] PRE_MAX =
    PW'(PRESCALE - 1);
  localparam logic [KW-1:0] KICK_LOAD =
    KW'(KICK_PERIODS);
  localparam logic [WW-1:0] STALE_MAX =
    WW'(STALE_CYCLES);

  // Entry thresholds, 13-bit unsigned.
  localparam logic [12:0] TH_ON   = 13'(T_ON);
  localparam logic [12:0] TH_HIGH = 13'(T_HIGH);
  localparam logic [12:0] TH_FULL = 13'(T_FULL);
  localparam logic [12:0] TH_OVER = 13'(T_OVER);

  // Exit thresholds, clamped at zero.
  localparam logic [12:0] EX_ON =
    (T_ON > HYST) ? 13'(T_ON - HYST) : 13'd0;
  localparam logic [12:0] EX_HIGH =
    (T_HIGH > HYST) ? 13'(T_HIGH - HYST) : 13'd0;
  localparam logic [12:0] EX_FULL =
    (T_FULL > HYST) ? 13'(T_FULL - HYST) : 13'd0;
  localparam logic [12:0] EX_OVER =
    (T_OVER > HYST) ? 13'(T_OVER - HYST) : 13'd0;

  localparam logic [7:0] DUTY_LOW  = 8'h80;
  localparam logic [7:0] DUTY_HIGH = 8'hC0;

  state_e         state_q, state_d;
  logic [KW-1:0]  kick_q, kick_d;
  logic [7:0]     duty_q, duty_d;
  logic           full_q, full_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [7:0]     pwm_cnt_q, pwm_cnt_d;
  logic           pwm_q, pwm_d;
  logic [WW-1:0]  wdog_q, wdog_d;
  logic           stale_q, stale_d;
  logic           over_q, over_d;

  logic [12:0]    temp13;
  state_e         target;
  state_e         eff;
  logic [12:0]    exit_thr;
  logic           presc_wrap;
  logic           boundary;
  logic           to_off;
  logic           leave_off;

  assign temp13 = {1'b0, temp};

  // Highest level the sample qualifies for.
  always_comb begin
    target = S_OFF;
    if (temp13 >= TH_FULL) begin
      target = S_FULL;
    end else if (temp13 >= TH_HIGH) begin
      target = S_HIGH;
    end else if (temp13 >= TH_ON) begin
      target = S_LOW;
    end
  end

  // Exit threshold of the current level; OFF
  // uses 0 so it can never step down.
  always_comb begin
    exit_thr = 13'd0;
    unique case (state_q)
      S_LOW:   exit_thr = EX_ON;
      S_HIGH:  exit_thr = EX_HIGH;
      S_FULL:  exit_thr = EX_FULL;
      default: exit_thr = 13'd0;
    endcase
  end

  // Level FSM next-state.
  always_comb begin
    state_d = state_q;
    if (temp_valid) begin
      if (2'(target) > 2'(state_q)) begin
        state_d = target;
      end else if (temp13 < exit_thr) begin
        state_d = state_e'(2'(state_q) - 2'd1);
      end
    end
  end

  assign to_off =
    (state_q != S_OFF) && (state_d == S_OFF);
  assign leave_off =
    (state_q == S_OFF) && (state_d != S_OFF);

  // Prescaler and PWM tick counter.
  assign presc_wrap = (presc_q == PRE_MAX);
  assign boundary =
    presc_wrap && (pwm_cnt_q == 8'hFF);

  always_comb begin
    presc_d   = presc_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q;
    if (presc_wrap) begin
      presc_d   = '0;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end
  end

  // Kick-start: a freshly started fan gets
  // full drive for a number of whole periods.
  always_comb begin
    kick_d = kick_q;
    if (boundary && (kick_q != '0)) begin
      kick_d = kick_q - 1'b1;
    end
    if (leave_off) begin
      kick_d = KICK_LOAD;
    end
    if (to_off) begin
      kick_d = '0;
    end
  end

  // Stale samples or kick override the level.
  always_comb begin
    eff = state_q;
    if (stale_q || (kick_q != '0)) begin
      eff = S_FULL;
    end
  end

  // Duty reloads only at a period boundary so
  // no runt pulses; dropping to OFF is immediate.
  always_comb begin
    duty_d = duty_q;
    full_d = full_q;
    if (to_off) begin
      duty_d = 8'h00;
      full_d = 1'b0;
    end else if (boundary) begin
      unique case (eff)
        S_LOW: begin
          duty_d = DUTY_LOW;
          full_d = 1'b0;
        end
        S_HIGH: begin
          duty_d = DUTY_HIGH;
          full_d = 1'b0;
        end
        S_FULL: begin
          duty_d = 8'hFF;
          full_d = 1'b1;
        end
        default: begin
          duty_d = 8'h00;
          full_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pwm_d = full_q | (pwm_cnt_q < duty_q);
    if (to_off) begin
      pwm_d = 1'b0;
    end
  end

  // Over-temperature flag with hysteresis.
  always_comb begin
    over_d = over_q;
    if (temp_valid) begin
      if (temp13 >= TH_OVER) begin
        over_d = 1'b1;
      end else if (temp13 < EX_OVER) begin
        over_d = 1'b0;
      end
    end
  end

  // Watchdog saturates; a valid sample always
  // wins over expiry in the same cycle.
  always_comb begin
    wdog_d = wdog_q;
    if (temp_valid) begin
      wdog_d = '0;
    end else if (wdog_q != STALE_MAX) begin
      wdog_d = wdog_q + 1'b1;
    end
    stale_d = !temp_valid && (wdog_d == STALE_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_OFF;
      kick_q    <= '0;
      duty_q    <= 8'h00;
      full_q    <= 1'b0;
      presc_q   <= '0;
      pwm_cnt_q <= 8'h00;
      pwm_q     <= 1'b0;
      wdog_q    <= '0;
      stale_q   <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      kick_q    <= kick_d;
      duty_q    <= duty_d;
      full_q    <= full_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
      wdog_q    <= wdog_d;
      stale_q   <= stale_d;
      over_q    <= over_d;
    end
  end

  assign fan_pwm    = pwm_q;
  assign fan_state  = state_q;
  assign over_temp  = over_q;
  assign temp_stale = stale_q;

endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// Directed testbench for fan_pwm_ctrl.
// PRESCALE=2 (512-clock period), STALE_CYCLES=1000.
module tb_fan_pwm_ctrl;

  logic        clk;
  logic        rst;
  logic [11:0] temp;
  logic        temp_valid;
  logic        fan_pwm;
  logic [1:0]  fan_state;
  logic        over_temp;
  logic        temp_stale;

  int          checks;
  int          failures;
  int          ecnt;
  int          bad;
  bit          keep_en;
  logic [11:0] keep_temp;

  fan_pwm_ctrl #(
    .PRESCALE     (2),
    .T_ON         (1200),
    .T_HIGH       (1400),
    .T_FULL       (1600),
    .T_OVER       (1800),
    .HYST         (40),
    .KICK_PERIODS (8),
    .STALE_CYCLES (1000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .temp       (temp),
    .temp_valid (temp_valid),
    .fan_pwm    (fan_pwm),
    .fan_state  (fan_state),
    .over_temp  (over_temp),
    .temp_stale (temp_stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h",
             tag, got, exp);
    end
  endtask

  // One clock; ecnt = edges since reset release.
  // Optional keep-alive samples every 400 edges.
  task automatic tick();
    @(negedge clk);
    ecnt++;
    if (keep_en && (ecnt % 400 == 399)) begin
      temp       = keep_temp;
      temp_valid = 1'b1;
    end else begin
      temp_valid = 1'b0;
    end
  endtask

  task automatic run_to(input int n);
    while (ecnt < n) tick();
  endtask

  task automatic send(input logic [11:0] t);
    temp       = t;
    temp_valid = 1'b1;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pwm"},   32'(fan_pwm),    0);
    chk({tag, "_state"}, 32'(fan_state),  0);
    chk({tag, "_over"},  32'(over_temp),  0);
    chk({tag, "_stale"}, 32'(temp_stale), 0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    ecnt       = 0;
    keep_en    = 1'b0;
    keep_temp  = 12'd0;
    rst        = 1'b1;
    temp       = 12'd0;
    temp_valid = 1'b0;

    // Reset and idle watchdog.
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst  = 1'b0;
    ecnt = 0;
    bad  = 0;
    while (ecnt < 999) begin
      tick();
      if (fan_pwm !== 1'b0 || fan_state !== 2'd0 ||
          over_temp !== 1'b0 || temp_stale !== 1'b0)
        bad++;
    end
    chk("idle_quiet", 32'(bad), 0);
    tick();
    chk("stale_set",   32'(temp_stale), 1);
    chk("stale_state", 32'(fan_state),  0);
    chk("stale_over",  32'(over_temp),  0);
    run_to(1024);
    chk("stale_pre_bnd", 32'(fan_pwm), 0);
    run_to(1025);
    chk("stale_full", 32'(fan_pwm), 1);
    run_to(1100);
    chk("stale_full2", 32'(fan_pwm), 1);

    // Step up with kick.
    rst = 1'b1;
    tick();
    chk_all_zero("rst2");
    rst        = 1'b0;
    ecnt       = 0;
    keep_en    = 1'b1;
    keep_temp  = 12'd1250;
    temp       = 12'd1250;
    temp_valid = 1'b1;
    tick();
    chk("kick_state", 32'(fan_state), 1);
    run_to(512);
    chk("kick_pre_bnd", 32'(fan_pwm), 0);
    run_to(513);
    chk("kick_start", 32'(fan_pwm), 1);
    bad = 0;
    while (ecnt < 4864) begin
      tick();
      if (fan_pwm !== 1'b1) bad++;
    end
    chk("kick_hold_high", 32'(bad), 0);
    chk("kick_stale", 32'(temp_stale), 0);
    run_to(4865);
    chk("low_fall", 32'(fan_pwm), 0);
    run_to(5120);
    chk("low_low_end", 32'(fan_pwm), 0);
    run_to(5121);
    chk("low_rise", 32'(fan_pwm), 1);
    chk("low_state", 32'(fan_state), 1);
    keep_en = 1'b0;

    // Direct jump, stepwise descent.
    send(12'd1700);
    chk("jump_full", 32'(fan_state), 3);
    send(12'd1150);
    chk("down_high", 32'(fan_state), 2);
    send(12'd1150);
    chk("down_low", 32'(fan_state), 1);
    send(12'd1150);
    chk("down_off", 32'(fan_state), 0);
    chk("off_pwm", 32'(fan_pwm), 0);

    // Hysteresis band.
    send(12'd1450);
    chk("hys_high", 32'(fan_state), 2);
    send(12'd1370);
    chk("hys_hold", 32'(fan_state), 2);
    send(12'd1359);
    chk("hys_drop", 32'(fan_state), 1);

    // Over-temperature.
    send(12'd1800);
    chk("ot_set", 32'(over_temp), 1);
    chk("ot_state", 32'(fan_state), 3);
    send(12'd1765);
    chk("ot_hold", 32'(over_temp), 1);
    send(12'd1759);
    chk("ot_clear", 32'(over_temp), 0);

    // Valid in the exact expiry cycle, then reset mid-kick.
    rst = 1'b1;
    tick();
    chk_all_zero("rst3");
    rst  = 1'b0;
    ecnt = 0;
    run_to(999);
    chk("pre_exp_stale", 32'(temp_stale), 0);
    send(12'd1300);
    chk("coll_stale", 32'(temp_stale), 0);
    chk("coll_state", 32'(fan_state),  1);
    run_to(1030);
    chk("coll_stale2", 32'(temp_stale), 0);
    chk("coll_kick", 32'(fan_pwm), 1);
    send(12'd1850);
    chk("coll_over", 32'(over_temp), 1);
    rst = 1'b1;
    tick();
    chk_all_zero("rst_kick");
    rst = 1'b0;
    tick();
    chk("post_rst_pwm", 32'(fan_pwm), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
